// File: rtl/wb_master_initiator.sv
// Single-outstanding Wishbone classic initiator: one bus cycle and one response per command.
// Latency: accept at edge N -> cyc/stb from N+1; ack/err sampled at edge K -> rsp_valid from K+1.
// Backpressure: cmd_ready only in IDLE; the response is held stable in RESP until rsp_ready.
module wb_master_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  timeout_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    // Counter only needs to reach TIMEOUT-1, the last cycle before the abort edge.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                bus_done;
    logic                tmo_hit;

    assign bus_done = wb_ack_i | wb_err_i;
    assign tmo_hit  = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST) && !bus_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = BUS;
            BUS:     if (bus_done || tmo_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs decode straight from the state register, so async reset drops cyc/stb at once.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        wb_cyc_o  = (state == BUS);
        wb_stb_o  = (state == BUS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_o       <= 1'b0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
            wait_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_dat       <= '0;
            rsp_err       <= 1'b0;
            rsp_timeout   <= 1'b0;
            err_count     <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_we_o  <= cmd_we;
                        wb_adr_o <= cmd_adr;
                        wb_dat_o <= cmd_dat;
                        wb_sel_o <= cmd_sel;
                        wait_cnt <= '0;
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        // err dominates a simultaneous ack; only a clean read ack returns data.
                        rsp_valid <= 1'b1;
                        rsp_err   <= wb_err_i;
                        rsp_dat   <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
                        if (wb_err_i && (err_count != '1)) begin
                            err_count <= err_count + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_dat     <= '0;
                        if (timeout_count != '1) begin
                            timeout_count <= timeout_count + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_dat     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
